timer_ctrl: RTL and testbench

- Control stage directly upstream of the digit-timer chain.
- Divides the system clock into a one-cycle decrement pulse for the least-significant digit's borrow-down input, and drives the chain-wide reconfig.
- Watches the least-significant digit's "cannot borrow" output to detect that the whole count has reached zero.
- Runs an IDLE/RUN/PAUSE/DONE state machine from start/stop/load button pulses.

---
 rtl/timer_pkg.sv | 15 +
 rtl/tick_div.sv | 51 +++++
 rtl/timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the digit-timer control stage: FSM state encoding
// and default prescaler sizing.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DIV_DEFAULT   = 100000000;
    localparam int CNT_W_DEFAULT = 27;

endpackage

// File: rtl/tick_div.sv
// Prescaler: counts 0..DIV-1 while enabled and emits a registered one-cycle
// wrap pulse; clear has priority over hold, and hold over enable.
module tick_div
    import timer_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic hold,
    input  logic pulse_en,
    output logic last,
    output logic wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    assign last = (cnt_q == CNT_W'(DIV - 1));
    assign wrap = wrap_q;

    // pulse_en lets the counter keep running without producing visible wraps
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold && en) begin
            if (last) begin
                cnt_d  = '0;
                wrap_d = pulse_en;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Timer control FSM (IDLE/RUN/PAUSE/DONE) driving the digit chain's decrement
// tick and reconfig; optional alarm enabled by defining TIMER_ALARM_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int ALARM_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic       zero,
    output logic       tick,
    output logic       reconfig,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic [1:0] state
);

    state_t state_q, state_d;
    logic   reconfig_q, running_q, done_q, alarm_q, alarm_d;
    logic   div_en, div_clr, div_hold, div_last, div_wrap;

    tick_div #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (div_en),
        .clr      (div_clr),
        .hold     (div_hold),
        .pulse_en (state_q == S_RUN),
        .last     (div_last),
        .wrap     (div_wrap)
    );

    always_comb begin
        state_d  = state_q;
        div_en   = 1'b0;
        div_clr  = 1'b0;
        div_hold = 1'b0;
        if (load) begin
            state_d = S_IDLE;
            div_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_clr = 1'b1;
                    if (start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (zero) begin
                        state_d = S_DONE;
                        div_clr = 1'b1;
                    end else if (stop) begin
                        state_d  = S_PAUSE;
                        div_hold = 1'b1;
                    end else begin
                        div_en = 1'b1;
                    end
                end
                S_PAUSE: begin
                    // resume edge keeps the count as-is
                    div_hold = 1'b1;
                    if (start) state_d = S_RUN;
                end
                default: begin
                    div_clr = 1'b1;
`ifdef TIMER_ALARM_EN
                    if (alarm_q) begin
                        div_clr = 1'b0;
                        div_en  = 1'b1;
                    end
`endif
                end
            endcase
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int AW = $clog2(ALARM_LEN + 1);
    logic [AW-1:0] alm_cnt_q, alm_cnt_d;

    // alarm lasts ALARM_LEN prescaler wraps counted from DONE entry
    always_comb begin
        alarm_d   = alarm_q;
        alm_cnt_d = alm_cnt_q;
        if (load) begin
            alarm_d   = 1'b0;
            alm_cnt_d = '0;
        end else if (state_q == S_RUN && zero) begin
            alarm_d   = 1'b1;
            alm_cnt_d = '0;
        end else if (state_q == S_DONE && alarm_q && div_last) begin
            if (alm_cnt_q == AW'(ALARM_LEN - 1)) begin
                alarm_d   = 1'b0;
                alm_cnt_d = '0;
            end else begin
                alm_cnt_d = alm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) alm_cnt_q <= '0;
        else      alm_cnt_q <= alm_cnt_d;
    end
`else
    logic unused_ok;
    assign unused_ok = div_last & (ALARM_LEN > 0);
    assign alarm_d   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            reconfig_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            reconfig_q <= load;
            running_q  <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
            alarm_q    <= alarm_d;
        end
    end

    assign tick     = div_wrap;
    assign reconfig = reconfig_q;
    assign running  = running_q;
    assign done     = done_q;
    assign alarm    = alarm_q;
    assign state    = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with DIV=4, ALARM_LEN=3.
module tb_timer_ctrl;

    localparam int DIV       = 4;
    localparam int ALARM_LEN = 3;
`ifdef TIMER_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic       clk, rst, start, stop, load, zero;
    logic       tick, reconfig, running, done, alarm;
    logic [1:0] state;

    timer_ctrl #(
        .DIV       (DIV),
        .CNT_W     (3),
        .ALARM_LEN (ALARM_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .zero     (zero),
        .tick     (tick),
        .reconfig (reconfig),
        .running  (running),
        .done     (done),
        .alarm    (alarm),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic       reconfig;
        logic       running;
        logic       done;
        logic       alarm;
        logic [1:0] state;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [1:0] m_state  = 2'd0;
    int         m_cnt    = 0;
    logic       m_alarm  = 1'b0;
    int         m_wraps  = 0;

    logic       last_tick, last_alarm;
    logic [1:0] last_state;
    logic [31:0] tv;
    int          acnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic p,
                         input logic l, input logic z, output exp_t e);
        logic e_tick, e_rec;
        e_tick = 1'b0;
        e_rec  = 1'b0;
        if (!r) begin
            m_state = 2'd0; m_cnt = 0; m_alarm = 1'b0; m_wraps = 0;
        end else if (l) begin
            m_state = 2'd0; m_cnt = 0; m_alarm = 1'b0; m_wraps = 0; e_rec = 1'b1;
        end else begin
            case (m_state)
                2'd0: if (s) begin m_state = 2'd1; m_cnt = 0; end
                2'd1: begin
                    if (z) begin
                        m_state = 2'd3; m_cnt = 0; m_alarm = ALARM_ON; m_wraps = 0;
                    end else if (p) begin
                        m_state = 2'd2;
                    end else if (m_cnt == DIV - 1) begin
                        m_cnt = 0; e_tick = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
                2'd2: if (s) m_state = 2'd1;
                default: begin
                    if (m_alarm) begin
                        if (m_cnt == DIV - 1) begin
                            m_cnt = 0;
                            m_wraps++;
                            if (m_wraps == ALARM_LEN) m_alarm = 1'b0;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            endcase
        end
        e.tick     = e_tick;
        e.reconfig = e_rec;
        e.running  = (m_state == 2'd1);
        e.done     = (m_state == 2'd3);
        e.alarm    = m_alarm;
        e.state    = m_state;
    endtask

    // drive one edge's inputs, predict, then compare after the edge
    task automatic step(input logic r, input logic s, input logic p,
                        input logic l, input logic z);
        exp_t e, o;
        rst = r; start = s; stop = p; load = l; zero = z;
        model(r, s, p, l, z, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            chk("tick",     {31'd0, tick},     {31'd0, o.tick});
            chk("reconfig", {31'd0, reconfig}, {31'd0, o.reconfig});
            chk("running",  {31'd0, running},  {31'd0, o.running});
            chk("done",     {31'd0, done},     {31'd0, o.done});
            chk("alarm",    {31'd0, alarm},    {31'd0, o.alarm});
            chk("state",    {30'd0, state},    {30'd0, o.state});
        end
        last_tick  = tick;
        last_alarm = alarm;
        last_state = state;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; zero = 1'b0;

        // reset state
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_state", {30'd0, state}, 32'd0);

        // start at E0: ticks after E4, E8, E12
        step(1, 1, 0, 0, 0);
        chk("run_after_start", {31'd0, running}, 32'd1);
        tv = '0;
        for (int k = 1; k <= 13; k++) begin
            step(1, 0, 0, 0, 0);
            tv[k] = last_tick;
        end
        chk("run_ticks", tv, 32'h0000_1110);

        // reset mid-RUN for two edges, then silence
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_mid_run", {30'd0, state}, 32'd0);
        tv = '0;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 0, 0);
            tv[k] = last_tick;
        end
        chk("post_rst_ticks", tv, 32'd0);

        // pause with cnt=2 at E7, resume at E16
        step(1, 1, 0, 0, 0);
        tv = '0;
        for (int k = 1; k <= 23; k++) begin
            step(1, (k == 16), (k == 7), 0, (k == 10));
            tv[k] = last_tick;
            if (k == 7) chk("paused", {30'd0, last_state}, 32'd2);
        end
        chk("pause_ticks", tv, 32'h0044_0010);

        // count to zero: zero one cycle after the E8 tick
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        tv   = '0;
        acnt = 0;
        for (int k = 1; k <= 29; k++) begin
            step(1, (k > 9) && (k % 2 == 0), (k > 9) && (k % 2 == 1), 0, (k == 9));
            tv[k] = last_tick;
            if (k == 9) chk("done_state", {30'd0, last_state}, 32'd3);
            if (last_alarm) acnt++;
        end
        chk("done_ticks", tv, 32'h0000_0110);
        chk("alarm_len", acnt, ALARM_ON ? 32'd12 : 32'd0);

        // load from DONE
        step(1, 0, 0, 1, 0);
        chk("load_reconfig", {31'd0, reconfig}, 32'd1);
        chk("load_state", {30'd0, state}, 32'd0);
        step(1, 0, 0, 0, 0);
        chk("reconfig_1cyc", {31'd0, reconfig}, 32'd0);

        // zero and stop ignored in IDLE
        step(1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0);
        chk("idle_ignores", {30'd0, state}, 32'd0);

        // load beats start
        step(1, 1, 0, 0, 0);
        idle(3);
        step(1, 1, 0, 1, 0);
        chk("load_beats_start", {30'd0, state}, 32'd0);

        // zero in PAUSE ignored; zero+stop in RUN gives DONE
        step(1, 1, 0, 0, 0);
        idle(2);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("pause_ignores_zero", {30'd0, state}, 32'd2);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1);
        chk("zero_stop_done", {30'd0, state}, 32'd3);

        // load clears alarm immediately inside the alarm window
        idle(3);
        step(1, 0, 0, 1, 0);
        chk("load_clears_alarm", {31'd0, alarm}, 32'd0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
